mbist_top: RTL and testbench

Memory built-in self-test (MBIST) wrapper around a single-port 256×4 synchronous RAM. In functional mode the RAM is accessed directly from the external read/write, address and data pins. A one-cycle `start` pulse launches a March C- self-test: the controller takes over the RAM and raises a sticky `fail` flag on any read mismatch. This block is the top level of the memory test subsystem.

---
 rtl/mbist_top.sv | 174 +++++++++++++++++
 tb/tb_mbist_top.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mbist_top.sv
// mbist_top: single-port RAM with a March C- built-in self-test controller.
// In IDLE the RAM is driven straight from the functional pins; a start pulse
// hands the RAM to the controller, which walks the six March C- elements and
// latches a sticky fail flag on any read mismatch.
module mbist_top #(
   parameter int wcount  = 256,
   parameter int wlength = 4,
   localparam int AW     = $clog2(wcount)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               rwbarin,
   input  logic [wlength-1:0] datain,
   input  logic [AW-1:0]      address,
   output logic [wlength-1:0] dataout,
   output logic               fail
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [AW-1:0] last_addr = AW'(wcount - 1);

   state_t               state, state_nxt;
   logic [2:0]           elem, elem_nxt;
   logic [AW-1:0]        addr, addr_nxt;
   logic                 phase, phase_nxt;
   logic                 drain, drain_nxt;
   logic                 start_acc;

   logic                 op_en;
   logic                 op_rd;
   logic                 two_op;
   logic                 elem_down;
   logic                 elem_last_op;
   logic                 addr_end;
   logic [wlength-1:0]   op_wdata;
   logic [wlength-1:0]   op_exp;

   logic                 ram_we;
   logic                 ram_re;
   logic [AW-1:0]        ram_addr;
   logic [wlength-1:0]   ram_wdata;
   logic [wlength-1:0]   mem [wcount];

   logic                 vld_p0;
   logic [wlength-1:0]   exp_p0;

   // Decode the current March operation from element, phase and address.
   always_comb begin
      op_en        = (state == RUN) && !drain;
      two_op       = (elem != 3'd0) && (elem != 3'd5);
      op_rd        = two_op ? !phase : (elem == 3'd5);
      elem_down    = (elem == 3'd3) || (elem == 3'd4);
      elem_last_op = two_op ? phase : 1'b1;
      addr_end     = elem_down ? (addr == '0) : (addr == last_addr);
      op_wdata     = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;
      op_exp       = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
   end

   // Next-state logic: launch, element/address/phase sequencing, drain cycle.
   always_comb begin
      state_nxt = state;
      elem_nxt  = elem;
      addr_nxt  = addr;
      phase_nxt = phase;
      drain_nxt = drain;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               elem_nxt  = 3'd0;
               addr_nxt  = '0;
               phase_nxt = 1'b0;
               drain_nxt = 1'b0;
               start_acc = 1'b1;
            end
         end
         RUN: begin
            if (drain) begin
               // Last read is being compared this cycle; hand RAM back after it.
               state_nxt = IDLE;
               drain_nxt = 1'b0;
            end else if (!elem_last_op) begin
               phase_nxt = 1'b1;
            end else begin
               phase_nxt = 1'b0;
               if (!addr_end) begin
                  addr_nxt = elem_down ? (addr - 1'b1) : (addr + 1'b1);
               end else if (elem == 3'd5) begin
                  drain_nxt = 1'b1;
               end else begin
                  elem_nxt = elem + 3'd1;
                  // Elements 3 and 4 walk downward, so preload the top address.
                  addr_nxt = ((elem == 3'd2) || (elem == 3'd3)) ? last_addr : '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM port mux: controller owns the RAM in RUN, the pins own it in IDLE.
   always_comb begin
      if (state == RUN) begin
         ram_we    = op_en && !op_rd;
         ram_re    = op_en && op_rd;
         ram_addr  = addr;
         ram_wdata = op_wdata;
      end else begin
         ram_we    = !rwbarin;
         ram_re    = rwbarin;
         ram_addr  = address;
         ram_wdata = datain;
      end
   end

   // Controller state and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         elem  <= 3'd0;
         addr  <= '0;
         phase <= 1'b0;
         drain <= 1'b0;
      end else begin
         state <= state_nxt;
         elem  <= elem_nxt;
         addr  <= addr_nxt;
         phase <= phase_nxt;
         drain <= drain_nxt;
      end
   end

   // RAM array write; contents survive reset, but no write on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst && ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   // Registered read port; holds its value on write and idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataout <= '0;
      end else if (ram_re) begin
         dataout <= mem[ram_addr];
      end
   end

   // Stage p0: expected value captured alongside each self-test read.
   always_ff @(posedge clk) begin
      if (op_en && op_rd) begin
         exp_p0 <= op_exp;
      end
   end

   // Compare stage: read-valid tracking and the sticky fail flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         fail   <= 1'b0;
      end else begin
         vld_p0 <= op_en && op_rd;
         if (start_acc) begin
            fail <= 1'b0;
         end else if (vld_p0 && (dataout != exp_p0)) begin
            fail <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mbist_top.sv
// tb_mbist_top: randomized bench for mbist_top against a behavioural model
// that holds the RAM image as an array and derives each March C- operation
// from the element table with plain arithmetic.
module tb_mbist_top;

   localparam int WC = 256;
   localparam int WL = 4;
   localparam int AW = 8;
   localparam int N  = 10 * WC;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          rwbarin;
   logic [WL-1:0] datain;
   logic [AW-1:0] address;
   logic [WL-1:0] dataout;
   logic          fail;

   int            n_chk = 0;
   int            n_err = 0;

   logic [WL-1:0] ref_mem [WC];
   logic [WL-1:0] ref_dout;
   logic          ref_fail;
   logic [WL-1:0] fv;

   always #5 clk = ~clk;

   mbist_top #(.wcount(WC), .wlength(WL)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rwbarin (rwbarin),
      .datain  (datain),
      .address (address),
      .dataout (dataout),
      .fail    (fail)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // March C- operation k: address, read/write, and the value written or expected.
   task automatic march_op(input int k, output int a, output bit rd, output logic [WL-1:0] v);
      int kk, e, r, pos;
      if (k < WC) begin
         a = k; rd = 1'b0; v = '0;
      end else if (k < 9 * WC) begin
         kk  = k - WC;
         e   = 1 + kk / (2 * WC);
         r   = kk % (2 * WC);
         pos = r / 2;
         rd  = (r % 2) == 0;
         a   = (e == 3 || e == 4) ? (WC - 1 - pos) : pos;
         if (e == 2 || e == 4) v = rd ? '1 : '0;
         else                  v = rd ? '0 : '1;
      end else begin
         a = k - 9 * WC; rd = 1'b1; v = '0;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; start = 1'b0; rwbarin = 1'b1;
      repeat (n) @(negedge clk);
      ref_dout = '0; ref_fail = 1'b0;
      chk("rst_dout", 32'(dataout), 32'(ref_dout));
      chk("rst_fail", 32'(fail), 32'(ref_fail));
      rst = 1'b0;
   endtask

   task automatic func_write(input int a, input logic [WL-1:0] d);
      rwbarin = 1'b0; address = AW'(a); datain = d;
      @(negedge clk);
      ref_mem[a] = d;
      chk("wr_hold", 32'(dataout), 32'(ref_dout));
   endtask

   task automatic func_read(input string tag, input int a);
      rwbarin = 1'b1; address = AW'(a);
      @(negedge clk);
      ref_dout = ref_mem[a];
      chk(tag, 32'(dataout), 32'(ref_dout));
      chk("idle_fail", 32'(fail), 32'(ref_fail));
   endtask

   task automatic func_traffic(input int n);
      for (int j = 0; j < n; j++) begin
         if ($urandom_range(0, 1) == 0) func_write(int'($urandom_range(0, WC - 1)), WL'($urandom));
         else                           func_read("func_rd", int'($urandom_range(0, WC - 1)));
      end
   endtask

   task automatic run_test(input int rst_at, input int restart_at, input int fault_k,
                           input logic [WL-1:0] fault_val, input bit jitter, input bit start_at_end);
      int            a, a2, ba;
      bit            rd, mis_prev, aborted;
      logic [WL-1:0] v, obs, bx, by;
      mis_prev = 1'b0; aborted = 1'b0; ba = 0;
      rwbarin = 1'b1; address = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ref_fail = 1'b0;
      chk("start_clr", 32'(fail), 32'(ref_fail));
      for (int i = 1; i <= N + 1; i++) begin
         if (jitter) begin
            rwbarin = 1'($urandom); address = AW'($urandom); datain = WL'($urandom);
         end
         start = (i == restart_at) || (start_at_end && i == N + 1);
         if (i == N + 1) begin
            ba = int'($urandom_range(0, WC - 1));
            bx = WL'($urandom_range(1, 15));
            rwbarin = 1'b0; address = AW'(ba); datain = bx;
         end
         if (i == rst_at) rst = 1'b1;
         @(negedge clk);
         start = 1'b0;
         if (i == rst_at) begin
            rst = 1'b0; ref_dout = '0; ref_fail = 1'b0; aborted = 1'b1;
            chk("abort_fail", 32'(fail), 32'(ref_fail));
            chk("abort_dout", 32'(dataout), 32'(ref_dout));
            break;
         end
         if (mis_prev) ref_fail = 1'b1;
         mis_prev = 1'b0;
         chk("run_fail", 32'(fail), 32'(ref_fail));
         if (i <= N) begin
            march_op(i - 1, a, rd, v);
            if (rd) begin
               chk("run_rd", 32'(dataout), 32'(ref_mem[a]));
               ref_dout = ref_mem[a];
               obs = (fault_k >= 0 && i - 1 == fault_k) ? fault_val : ref_mem[a];
               mis_prev = (obs != v);
            end else begin
               ref_mem[a] = v;
            end
         end
         if (fault_k >= 0 && i - 1 == fault_k) begin
            fv = fault_val;
            force dut.dataout = fv;
         end
         if (fault_k >= 0 && i - 2 == fault_k) release dut.dataout;
      end
      if (!aborted) begin
         by = WL'($urandom_range(1, 15));
         func_write((ba + 1) % WC, by);
         func_read("end_ignored_wr", ba);
         func_read("end_first_wr", (ba + 1) % WC);
      end else begin
         march_op(rst_at - 2, a, rd, v);
         march_op(rst_at - 1, a2, rd, v);
         func_read("abort_rd", a);
         func_read("abort_rd", (a + 1) % WC);
         func_read("abort_rd", (a + WC - 1) % WC);
         func_read("abort_rd", a2);
         func_read("abort_rd", (a2 + 1) % WC);
         for (int j = 0; j < 4; j++) func_read("abort_rd", int'($urandom_range(0, WC - 1)));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rwbarin = 1'b1; address = '0; datain = '0;
      ref_dout = '0; ref_fail = 1'b0; fv = '0;
      do_reset(2);

      func_write(8'h05, 4'hA);
      func_write(8'hFF, 4'h3);
      func_read("rd_05", 8'h05);
      func_read("rd_ff", 8'hFF);
      func_write(8'h05, 4'h7);
      func_read("rd_05_new", 8'h05);
      do_reset(1);

      run_test(0, 0, -1, '0, 1'b0, 1'b0);
      func_traffic(150);
      run_test(0, 0, -1, '0, 1'b1, 1'b0);

      run_test(0, 1000, 384, 4'h4, 1'b1, 1'b1);
      func_traffic(20);
      run_test(0, 0, 290, 4'hF, 1'b1, 1'b0);
      func_read("held_rd", 8'h11);
      do_reset(1);

      func_traffic(150);
      run_test(int'($urandom_range(770, 1270)), 0, -1, '0, 1'b1, 1'b0);
      func_traffic(100);
      run_test(int'($urandom_range(2, N)), 300, -1, '0, 1'b0, 1'b0);
      run_test(0, 0, -1, '0, 1'b1, 1'b0);
      func_traffic(50);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
